adder_unit: RTL and testbench

- Parameterised two-operand binary adder with carry-in.
- Provides a zero-latency combinational sum/carry path and a one-cycle registered result stage with status flags and a valid qualifier.
- Used as a generic arithmetic leaf inside datapath/ALU blocks and as a standalone arithmetic unit in simulation.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/adder_cla4.sv | 40 ++++
 rtl/adder_unit.sv | 79 +++++++
 tb/tb_adder_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder_unit slice.
// Group width, registered flag bundle and overflow rule.
package adder_pkg;

  localparam int CLA_GROUP_W = 4;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } adder_flags_t;

  function automatic logic calc_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead group.
// Exposes group propagate/generate for higher-level lookahead.
module adder_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gg = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign pg = &p;

  assign cout = gg | (pg & cin);
  assign sum  = p ^ c;

endmodule

// File: rtl/adder_unit.sv
// Two-operand adder with carry-in: combinational sum/carry
// plus a one-cycle registered result with status flags.
module adder_unit
  import adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             valid_i,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_r,
  output logic             cout_r,
  output logic             ovf_r,
  output logic             zero_r,
  output logic             valid_r
);

  localparam int NG = WIDTH / CLA_GROUP_W;

  if ((WIDTH % CLA_GROUP_W) != 0 || WIDTH == 0) begin : g_bad_width
    $fatal(1, "adder_unit: WIDTH must be a positive multiple of 4");
  end

  logic [NG:0]   c;
  logic [NG-1:0] pg;
  logic [NG-1:0] gg;

  assign c[0] = cin;

  for (genvar i = 0; i < NG; i++) begin : g_cla
    adder_cla4 u_cla (
      .a    (a[i*CLA_GROUP_W +: CLA_GROUP_W]),
      .b    (b[i*CLA_GROUP_W +: CLA_GROUP_W]),
      .cin  (c[i]),
      .sum  (sum[i*CLA_GROUP_W +: CLA_GROUP_W]),
      .cout (c[i+1]),
      .pg   (pg[i]),
      .gg   (gg[i])
    );
  end

  assign cout = c[NG];

  // Group p/g serve wider lookahead trees; this level ripples.
  logic unused_pg_gg;
  assign unused_pg_gg = ^{pg, gg};

  adder_flags_t flags_d;
  adder_flags_t flags_q;

  assign flags_d.cout = cout;
  assign flags_d.ovf  = calc_ovf(a[WIDTH-1], b[WIDTH-1],
                                 sum[WIDTH-1]);
  assign flags_d.zero = (sum == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r   <= '0;
      flags_q <= '0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_i;
      if (valid_i) begin
        sum_r   <= sum;
        flags_q <= flags_d;
      end
    end
  end

  assign cout_r = flags_q.cout;
  assign ovf_r  = flags_q.ovf;
  assign zero_r = flags_q.zero;

endmodule

// File: tb/tb_adder_unit.sv
// Bench for adder_unit: 4-bit and 16-bit instances,
// scoreboard of expected registered results.
module tb_adder_unit;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        cin4 = 1'b0, v4 = 1'b0;
  logic [3:0]  sum4, sum_r4;
  logic        cout4, cout_r4, ovf_r4, zero_r4, valid_r4;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0, v16 = 1'b0;
  logic [15:0] sum16, sum_r16;
  logic        cout16, cout_r16, ovf_r16, zero_r16, valid_r16;

  int total = 0;
  int bad = 0;
  res_t sb4[$];
  res_t sb16[$];
  res_t held4 = '0;
  res_t held16 = '0;

  always #5 clk = ~clk;

  adder_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .valid_i(v4), .sum(sum4), .cout(cout4),
    .sum_r(sum_r4), .cout_r(cout_r4), .ovf_r(ovf_r4),
    .zero_r(zero_r4), .valid_r(valid_r4)
  );

  adder_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
    .valid_i(v16), .sum(sum16), .cout(cout16),
    .sum_r(sum_r16), .cout_r(cout_r16), .ovf_r(ovf_r16),
    .zero_r(zero_r16), .valid_r(valid_r16)
  );

  // Reference via integer arithmetic and signed range test.
  function automatic res_t model(input int w, input int ua,
                                 input int ub, input int uc);
    res_t r;
    int full, sa, sb, sv, lim;
    lim  = 1 << (w - 1);
    full = ua + ub + uc;
    sa   = (ua >= lim) ? ua - 2 * lim : ua;
    sb   = (ub >= lim) ? ub - 2 * lim : ub;
    sv   = sa + sb + uc;
    r.s  = 16'(full % (2 * lim));
    r.c  = (full >= 2 * lim);
    r.o  = (sv >= lim) || (sv < -lim);
    r.z  = (r.s == 0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step4(input int ta, input int tb, input int tc,
                       input logic tv, input logic tr);
    res_t e;
    @(negedge clk);
    a4 = 4'(ta); b4 = 4'(tb); cin4 = tc[0];
    v4 = tv; rst = tr;
    #1;
    e = model(4, ta, tb, tc);
    chk("sum4", 32'(sum4), 32'(e.s));
    chk("cout4", 32'(cout4), 32'(e.c));
    if (tv && !tr) sb4.push_back(e);
    @(posedge clk);
    #1;
    if (tr) held4 = '0;
    else if (tv) begin
      if (sb4.size() == 0) chk("sb4_empty", 32'd1, 32'd0);
      else held4 = sb4.pop_front();
    end
    chk("valid_r4", 32'(valid_r4), 32'(tv && !tr));
    chk("sum_r4", 32'(sum_r4), 32'(held4.s));
    chk("cout_r4", 32'(cout_r4), 32'(held4.c));
    chk("ovf_r4", 32'(ovf_r4), 32'(held4.o));
    chk("zero_r4", 32'(zero_r4), 32'(held4.z && !tr));
  endtask

  task automatic step16(input int ta, input int tb, input int tc,
                        input logic tv);
    res_t e;
    @(negedge clk);
    a16 = 16'(ta); b16 = 16'(tb); cin16 = tc[0];
    v16 = tv; rst = 1'b0; v4 = 1'b0;
    #1;
    e = model(16, ta, tb, tc);
    chk("sum16", 32'(sum16), 32'(e.s));
    chk("cout16", 32'(cout16), 32'(e.c));
    if (tv) sb16.push_back(e);
    @(posedge clk);
    #1;
    if (tv) begin
      if (sb16.size() == 0) chk("sb16_empty", 32'd1, 32'd0);
      else held16 = sb16.pop_front();
    end
    chk("valid_r16", 32'(valid_r16), 32'(tv));
    chk("sum_r16", 32'(sum_r16), 32'(held16.s));
    chk("cout_r16", 32'(cout_r16), 32'(held16.c));
    chk("ovf_r16", 32'(ovf_r16), 32'(held16.o));
    chk("zero_r16", 32'(zero_r16), 32'(held16.z));
  endtask

  initial begin
    step4(0, 0, 0, 1'b0, 1'b1);
    step4(0, 0, 0, 1'b0, 1'b0);
    // Directed cases, including hand-checked constants.
    step4(5, 6, 0, 1'b1, 1'b0);
    chk("d1_sum_r", 32'(sum_r4), 32'hB);
    chk("d1_ovf_r", 32'(ovf_r4), 32'd1);
    step4(15, 1, 0, 1'b1, 1'b0);
    chk("d2_zero_r", 32'(zero_r4), 32'd1);
    chk("d2_cout_r", 32'(cout_r4), 32'd1);
    step4(7, 0, 1, 1'b1, 1'b0);
    chk("d3_sum_r", 32'(sum_r4), 32'h8);
    step4(8, 8, 0, 1'b1, 1'b0);
    chk("d4_ovf_r", 32'(ovf_r4), 32'd1);
    // Back-to-back stream then idle hold.
    step4(1, 2, 0, 1'b1, 1'b0);
    step4(3, 4, 0, 1'b1, 1'b0);
    step4(9, 9, 0, 1'b1, 1'b0);
    chk("st_sum_r", 32'(sum_r4), 32'h2);
    step4(4, 4, 0, 1'b0, 1'b0);
    step4(1, 1, 1, 1'b0, 1'b0);
    chk("hold_sum_r", 32'(sum_r4), 32'h2);
    // Reset beats valid_i; comb path ignores rst.
    step4(5, 6, 0, 1'b1, 1'b1);
    chk("rst_sum", 32'(sum4), 32'hB);
    step4(5, 6, 0, 1'b0, 1'b0);
    step4(2, 3, 0, 1'b1, 1'b0);
    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 512; i++)
      step4(i & 15, (i >> 4) & 15, i >> 8, 1'b1, 1'b0);
    // Wide instance.
    step16(16'hFFFF, 16'h0001, 1, 1'b1);
    chk("w_sum_r", 32'(sum_r16), 32'h0001);
    step16(16'h7FFF, 16'h0001, 0, 1'b1);
    step16(16'h8000, 16'h8000, 0, 1'b1);
    step16(16'h1234, 16'h4321, 1, 1'b0);
    for (int i = 0; i < 40; i++)
      step16(int'($urandom_range(65535)),
             int'($urandom_range(65535)),
             int'($urandom_range(1)), 1'($urandom_range(1)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
